// File: rtl/halfword_insn_buffer_pkg.sv
// ==== halfword_insn_buffer_pkg : shared types for the halfword instruction buffer ====
// ==== rev 1.0 ====
`default_nettype none

package halfword_insn_buffer_pkg;

  localparam int INSN_BUFFER_ENTRY_COUNT = 8;
  localparam int INSN_BUFFER_FETCH_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] insn;
    logic        fault;
    logic        interruptValid;
    logic [3:0]  interruptCode;
  } InsnBufferEntry;

  localparam int INSN_BUFFER_ENTRY_WIDTH = $bits(InsnBufferEntry);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        compressed;
    logic        fault;
    logic        interruptValid;
    logic [3:0]  interruptCode;
  } InsnBufferOutput;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/halfword_insn_buffer_storage.sv
// ==== halfword_insn_buffer_storage : halfword register array, FETCH_WIDTH writes, 2 reads ====
// ==== rev 1.0 ====
`default_nettype none

module halfword_insn_buffer_storage
  import halfword_insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT,
  parameter int FETCH_WIDTH = INSN_BUFFER_FETCH_WIDTH
) (
  input  logic                             clk,
  input  logic [FETCH_WIDTH-1:0]           wr_en,
  input  logic [$clog2(ENTRY_COUNT)-1:0]   wr_base,
  input  InsnBufferEntry [FETCH_WIDTH-1:0] wr_data,
  input  logic [$clog2(ENTRY_COUNT)-1:0]   rd_addr,
  output InsnBufferEntry                   rd_data0,
  output InsnBufferEntry                   rd_data1
);

  localparam int AW = $clog2(ENTRY_COUNT);

  InsnBufferEntry mem [ENTRY_COUNT];

  // Lanes land on consecutive slots; the power-of-two depth makes the wrap free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (wr_en[i]) begin
        mem[wr_base + AW'(i)] <= wr_data[i];
      end
    end
  end

  assign rd_data0 = mem[rd_addr];
  assign rd_data1 = mem[rd_addr + AW'(1)];

endmodule

`default_nettype wire

// File: rtl/halfword_insn_buffer.sv
// ==== halfword_insn_buffer : circular halfword queue emitting one RV32C-aware insn per cycle ====
// ==== rev 1.0 ====
`default_nettype none

module halfword_insn_buffer
  import halfword_insn_buffer_pkg::*;
#(
  parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT,
  parameter int FETCH_WIDTH = INSN_BUFFER_FETCH_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         flush,
  output logic                                         enqReady,
  input  logic [FETCH_WIDTH-1:0]                       enqValid,
  input  logic [FETCH_WIDTH*INSN_BUFFER_ENTRY_WIDTH-1:0] enqEntry,
  input  logic                                         deqReady,
  output logic                                         deqValid,
  output logic [31:0]                                  deqPc,
  output logic [31:0]                                  deqInsn,
  output logic                                         deqCompressed,
  output logic                                         deqFault,
  output logic                                         deqInterruptValid,
  output logic [3:0]                                   deqInterruptCode,
  output logic [$clog2(ENTRY_COUNT):0]                 count
);

  localparam int AW = $clog2(ENTRY_COUNT);
  localparam int CW = AW + 1;
  localparam int EW = INSN_BUFFER_ENTRY_WIDTH;
  localparam logic [CW-1:0] EC_CNT = CW'(ENTRY_COUNT);
  localparam logic [CW-1:0] FW_CNT = CW'(FETCH_WIDTH);

  logic [AW-1:0]                    head;
  logic [AW-1:0]                    tail;
  InsnBufferEntry [FETCH_WIDTH-1:0] lane_entry;
  InsnBufferEntry                   hw0;
  InsnBufferEntry                   hw1;
  logic [CW-1:0]                    n_enq;
  logic [CW-1:0]                    deq_size;
  logic [FETCH_WIDTH-1:0]           wr_en;
  logic                             pair;
  logic                             enq_fire;
  logic                             deq_fire;
  InsnBufferOutput                  deq_out;
  logic                             unused_hw1_pc;

  generate
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
      assign lane_entry[i] = enqEntry[i*EW +: EW];
    end
  endgenerate

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      n_enq = n_enq + CW'(enqValid[i]);
    end
  end

  // Free-slot check deliberately ignores any same-cycle dequeue.
  assign enqReady = (EC_CNT - count) >= FW_CNT;
  assign enq_fire = enqReady && (|enqValid);
  assign wr_en    = enqValid & {FETCH_WIDTH{enq_fire && !flush && !rst}};

  halfword_insn_buffer_storage #(
    .ENTRY_COUNT (ENTRY_COUNT),
    .FETCH_WIDTH (FETCH_WIDTH)
  ) u_storage (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_base  (tail),
    .wr_data  (lane_entry),
    .rd_addr  (head),
    .rd_data0 (hw0),
    .rd_data1 (hw1)
  );

  // A tagged lower half is handed over alone so the fault/interrupt is not delayed.
  assign pair     = !is_compressed(hw0.insn) && !hw0.fault && !hw0.interruptValid;
  assign deq_size = pair ? CW'(2) : CW'(1);
  assign deqValid = count >= deq_size;
  assign deq_fire = deqValid && deqReady;

  always_comb begin
    deq_out = '0;
    if (deqValid) begin
      deq_out.pc             = hw0.pc;
      deq_out.compressed     = is_compressed(hw0.insn);
      deq_out.insn           = pair ? {hw1.insn, hw0.insn} : {16'h0000, hw0.insn};
      deq_out.fault          = hw0.fault | (pair & hw1.fault);
      deq_out.interruptValid = hw0.interruptValid | (pair & hw1.interruptValid);
      if (hw0.interruptValid) begin
        deq_out.interruptCode = hw0.interruptCode;
      end else if (pair && hw1.interruptValid) begin
        deq_out.interruptCode = hw1.interruptCode;
      end
    end
  end

  assign deqPc             = deq_out.pc;
  assign deqInsn           = deq_out.insn;
  assign deqCompressed     = deq_out.compressed;
  assign deqFault          = deq_out.fault;
  assign deqInterruptValid = deq_out.interruptValid;
  assign deqInterruptCode  = deq_out.interruptCode;
  assign unused_hw1_pc     = ^hw1.pc;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) begin
        tail <= tail + n_enq[AW-1:0];
      end
      if (deq_fire) begin
        head <= head + deq_size[AW-1:0];
      end
      count <= count + (enq_fire ? n_enq : '0) - (deq_fire ? deq_size : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= EC_CNT);
      if (|enqValid) begin
        assert ((enqValid & (enqValid + FETCH_WIDTH'(1))) == '0);
      end
      if (enq_fire) begin
        assert ((count + n_enq) <= EC_CNT);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_halfword_insn_buffer.sv
// ==== tb_halfword_insn_buffer : directed scoreboard bench, ENTRY_COUNT=4 FETCH_WIDTH=2 ====
// ==== rev 1.0 ====
`default_nettype none

module tb_halfword_insn_buffer;
  import halfword_insn_buffer_pkg::*;

  localparam int EC = 4;
  localparam int FW = 2;
  localparam int EW = INSN_BUFFER_ENTRY_WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             enqReady;
  logic [FW-1:0]    enqValid;
  logic [FW*EW-1:0] enqEntry;
  logic             deqReady;
  logic             deqValid;
  logic [31:0]      deqPc;
  logic [31:0]      deqInsn;
  logic             deqCompressed;
  logic             deqFault;
  logic             deqInterruptValid;
  logic [3:0]       deqInterruptCode;
  logic [2:0]       count;

  always #5 clk = ~clk;

  halfword_insn_buffer #(.ENTRY_COUNT(EC), .FETCH_WIDTH(FW)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .enqReady          (enqReady),
    .enqValid          (enqValid),
    .enqEntry          (enqEntry),
    .deqReady          (deqReady),
    .deqValid          (deqValid),
    .deqPc             (deqPc),
    .deqInsn           (deqInsn),
    .deqCompressed     (deqCompressed),
    .deqFault          (deqFault),
    .deqInterruptValid (deqInterruptValid),
    .deqInterruptCode  (deqInterruptCode),
    .count             (count)
  );

  InsnBufferOutput exp_q[$];
  int checks = 0;
  int errors = 0;

  // Stream of 16 halfwords and the instructions they decode to.
  logic [15:0] sh [16] = '{16'h4081, 16'h0513, 16'h1234, 16'h0593, 16'h5678, 16'h4102,
                           16'h4184, 16'h0613, 16'h9abc, 16'h4205, 16'h0693, 16'hdef0,
                           16'h4286, 16'h0713, 16'h1357, 16'h4308};
  int          e_idx [11] = '{0, 1, 3, 5, 6, 7, 9, 10, 12, 13, 15};
  logic [31:0] e_insn [11] = '{32'h00004081, 32'h12340513, 32'h56780593, 32'h00004102,
                               32'h00004184, 32'h9abc0613, 32'h00004205, 32'hdef00693,
                               32'h00004286, 32'h13570713, 32'h00004308};
  logic        e_c [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic InsnBufferEntry mk(input logic [31:0] pc, input logic [15:0] hw,
                                        input logic f = 1'b0, input logic iv = 1'b0,
                                        input logic [3:0] code = 4'h0);
    InsnBufferEntry e;
    e.pc = pc; e.insn = hw; e.fault = f; e.interruptValid = iv; e.interruptCode = code;
    return e;
  endfunction

  function automatic InsnBufferOutput ex(input logic [31:0] pc, input logic [31:0] insn,
                                         input logic c, input logic f = 1'b0,
                                         input logic iv = 1'b0, input logic [3:0] code = 4'h0);
    InsnBufferOutput o;
    o.pc = pc; o.insn = insn; o.compressed = c; o.fault = f;
    o.interruptValid = iv; o.interruptCode = code;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic monitor();
    InsnBufferOutput got;
    InsnBufferOutput e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && flush === 1'b0 && deqValid === 1'b1 && deqReady === 1'b1) begin
        got.pc = deqPc; got.insn = deqInsn; got.compressed = deqCompressed;
        got.fault = deqFault; got.interruptValid = deqInterruptValid;
        got.interruptCode = deqInterruptCode;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deq_unexpected: got pc=%h insn=%h expected no output", got.pc, got.insn);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL deq: got pc=%h insn=%h c=%b f=%b iv=%b code=%h expected pc=%h insn=%h c=%b f=%b iv=%b code=%h",
                     got.pc, got.insn, got.compressed, got.fault, got.interruptValid, got.interruptCode,
                     e.pc, e.insn, e.compressed, e.fault, e.interruptValid, e.interruptCode);
          end
        end
      end
    end
  endtask

  task automatic drive(input InsnBufferEntry e0, input InsnBufferEntry e1, input logic [FW-1:0] m);
    enqEntry = {e1, e0};
    enqValid = m;
    @(posedge clk); #1;
    enqValid = '0;
  endtask

  task automatic enq(input InsnBufferEntry e0, input InsnBufferEntry e1, input logic [FW-1:0] m);
    int n = 0;
    while (!enqReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!enqReady) begin
      checks++;
      errors++;
      $display("FAIL enq_timeout: got enqReady=0 expected 1");
    end
    drive(e0, e1, m);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((count != 0 || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_count"}, 32'(count), 0);
    chk({name, "_pending"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; deqReady = 1'b1; enqValid = '0; enqEntry = '0;
    fork
      monitor();
    join_none

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enqReady", 32'(enqReady), 1);
    chk("rst_deqValid", 32'(deqValid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_deqInsn", deqInsn, 0);
    rst = 1'b0;

    // 2. single 32-bit insn
    exp_q.push_back(ex(32'h80000000, 32'h00000513, 1'b0));
    enq(mk(32'h80000000, 16'h0513), mk(32'h80000002, 16'h0000), 2'b11);
    chk("t2_deqValid", 32'(deqValid), 1);
    chk("t2_deqPc", deqPc, 32'h80000000);
    wait_empty("t2");

    // 3. 32-bit insn split across enqueues, pair wraps 3->0
    exp_q.push_back(ex(32'h80000000, 32'h00004501, 1'b1));
    enq(mk(32'h80000000, 16'h4501), mk(32'h80000002, 16'h0513), 2'b11);
    @(posedge clk); #1;
    chk("t3_wait_valid", 32'(deqValid), 0);
    chk("t3_wait_count", 32'(count), 1);
    chk("t3_wait_insn", deqInsn, 0);
    chk("t3_wait_pc", deqPc, 0);
    @(posedge clk); #1;
    chk("t3_wait_valid2", 32'(deqValid), 0);
    exp_q.push_back(ex(32'h80000002, 32'h00000513, 1'b0));
    exp_q.push_back(ex(32'h80000006, 32'h00004505, 1'b1));
    enq(mk(32'h80000004, 16'h0000), mk(32'h80000006, 16'h4505), 2'b11);
    wait_empty("t3");

    // 4. full, ignored enqueue, then stream
    deqReady = 1'b0;
    exp_q.push_back(ex(32'h80000010, 32'h00000001, 1'b1));
    exp_q.push_back(ex(32'h80000012, 32'h00000005, 1'b1));
    exp_q.push_back(ex(32'h80000014, 32'h00000009, 1'b1));
    exp_q.push_back(ex(32'h80000016, 32'h0000000d, 1'b1));
    enq(mk(32'h80000010, 16'h0001), mk(32'h80000012, 16'h0005), 2'b11);
    enq(mk(32'h80000014, 16'h0009), mk(32'h80000016, 16'h000d), 2'b11);
    chk("t4_full_count", 32'(count), 4);
    chk("t4_full_enqReady", 32'(enqReady), 0);
    chk("t4_full_head", deqInsn, 32'h00000001);
    drive(mk(32'h80000018, 16'h0011), mk(32'h8000001a, 16'h0015), 2'b11);
    chk("t4_ignored_count", 32'(count), 4);
    deqReady = 1'b1;
    wait_empty("t4_drain");

    for (int k = 0; k < 11; k++) begin
      exp_q.push_back(ex(32'h80001000 + 32'(2 * e_idx[k]), e_insn[k], e_c[k]));
    end
    for (int p = 0; p < 8; p++) begin
      enq(mk(32'h80001000 + 32'(4 * p), sh[2*p]), mk(32'h80001002 + 32'(4 * p), sh[2*p+1]), 2'b11);
    end
    wait_empty("t4_stream");

    // 5. fault / interrupt tagging
    exp_q.push_back(ex(32'h80000000, 32'h00000513, 1'b0, 1'b1));
    enq(mk(32'h80000000, 16'h0513), mk(32'h80000002, 16'h0000, 1'b1), 2'b11);
    wait_empty("t5_fault_hi");

    exp_q.push_back(ex(32'h80000010, 32'h00000513, 1'b0, 1'b0, 1'b1, 4'h7));
    exp_q.push_back(ex(32'h80000012, 32'h00000000, 1'b1));
    enq(mk(32'h80000010, 16'h0513, 1'b0, 1'b1, 4'h7), mk(32'h80000012, 16'h0000), 2'b11);
    wait_empty("t5_irq_head");

    exp_q.push_back(ex(32'h80000020, 32'habcd0593, 1'b0, 1'b0, 1'b1, 4'h9));
    enq(mk(32'h80000020, 16'h0593), mk(32'h80000022, 16'habcd, 1'b0, 1'b1, 4'h9), 2'b11);
    wait_empty("t5_irq_hi");

    exp_q.push_back(ex(32'h80000030, 32'h00000613, 1'b0, 1'b1));
    exp_q.push_back(ex(32'h80000032, 32'h00004501, 1'b1));
    enq(mk(32'h80000030, 16'h0613, 1'b1), mk(32'h80000032, 16'h4501), 2'b11);
    wait_empty("t5_fault_head");

    exp_q.push_back(ex(32'h80000040, 32'h00004509, 1'b1));
    enq(mk(32'h80000040, 16'h4509), mk(32'h0, 16'h0), 2'b01);
    wait_empty("t5_one_lane");

    // reset while holding data
    deqReady = 1'b0;
    enq(mk(32'h80000050, 16'h4501), mk(32'h80000052, 16'h4505), 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_deqValid", 32'(deqValid), 0);

    // 6. flush colliding with enqueue and dequeue
    enq(mk(32'ha0000000, 16'h4501), mk(32'ha0000002, 16'h0513), 2'b11);
    enq(mk(32'ha0000004, 16'h0000), mk(32'h0, 16'h0), 2'b01);
    chk("t6_count3", 32'(count), 3);
    flush = 1'b1;
    deqReady = 1'b1;
    enqEntry = {mk(32'ha0000008, 16'h4509), mk(32'ha0000006, 16'h4505)};
    enqValid = 2'b11;
    @(posedge clk); #1;
    flush = 1'b0;
    enqValid = '0;
    chk("t6_flush_count", 32'(count), 0);
    chk("t6_flush_deqValid", 32'(deqValid), 0);
    chk("t6_flush_enqReady", 32'(enqReady), 1);
    exp_q.push_back(ex(32'hb0000000, 32'h00004505, 1'b1));
    exp_q.push_back(ex(32'hb0000002, 32'h00004509, 1'b1));
    enq(mk(32'hb0000000, 16'h4505), mk(32'hb0000002, 16'h4509), 2'b11);
    wait_empty("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
